// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK excitation driver.
//   DC_SETRESET / DC_TOGGLE : don't-care resolution policies for J/K.
//   state_e                 : driver FSM states.
//   ERR_CNT_W               : width of the saturating mismatch counter.
package jk_pkg;

    localparam int DC_SETRESET = 0;
    localparam int DC_TOGGLE   = 1;
    localparam int ERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/jk_excite_cell.sv
// jk_excite_cell: per-bit inverse of the JK characteristic equation.
//   q      in  current Q of one bank flip-flop
//   t      in  requested next Q
//   policy in  0 = set/reset form (don't-cares to 0), 1 = toggle form (J==K)
//   j, k   out excitation for that flip-flop
// Both forms give J=K=0 when t==q, so the flip-flop holds.
module jk_excite_cell (
    input  logic q,
    input  logic t,
    input  logic policy,
    output logic j,
    output logic k
);

    always_comb begin
        if (policy) begin
            // Any change is a toggle; no change is a hold.
            j = q ^ t;
            k = q ^ t;
        end else begin
            j = ~q & t;
            k = q & ~t;
        end
    end

endmodule

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: drives an external JK flip-flop bank to a requested state
// in one clock, then checks that the bank landed there.
//   clk, rst_n      clock shared with the bank; async active-low reset
//   in_valid/ready  target handshake; in_ready is high only in IDLE
//   in_target       requested next state of the bank
//   q_in            bank Q feedback
//   j_out, k_out    registered bank excitation, non-zero for one cycle per step
//   done, mismatch  one-cycle check result (mismatch only meaningful with done)
//   err_cnt         saturating count of mismatches since reset
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = DC_SETRESET
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_target,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q_in,
    output logic [WIDTH-1:0]     j_out,
    output logic [WIDTH-1:0]     k_out,
    output logic                 done,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic POLICY_TOGGLE = (DC_POLICY == DC_TOGGLE) ? 1'b1 : 1'b0;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [WIDTH-1:0]     j_q, j_d;
    logic [WIDTH-1:0]     k_q, k_d;
    logic                 done_q, done_d;
    logic                 mismatch_q, mismatch_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]     exc_j;
    logic [WIDTH-1:0]     exc_k;
    logic                 miss;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_excite_cell u_cell (
            .q      (q_in[i]),
            .t      (in_target[i]),
            .policy (POLICY_TOGGLE),
            .j      (exc_j[i]),
            .k      (exc_k[i])
        );
    end

    assign miss = (q_in != target_q);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    target_d = in_target;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                // The bank samples J/K at the edge leaving DRIVE; excitation
                // drops back to hold on that same edge.
                state_d = CHECK;
            end
            CHECK: begin
                done_d     = 1'b1;
                mismatch_d = miss;
                if (miss && (err_cnt_q != ERR_MAX)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset also clears J/K so an interrupted step leaves the bank holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign j_out    = j_q;
    assign k_out    = k_q;
    assign done     = done_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;

endmodule
